// File: rtl/mem_bus_ctrl.sv
// CPU-side memory bus controller: routes single loads/stores to a synchronous RAM,
// a write-only LED register or a synchronized switch port, and flags illegal accesses.
module mem_bus_ctrl #(
    parameter int          RAM_WAIT = 0,
    parameter logic [8:0]  LED_ADDR = 9'h100,
    parameter logic [8:0]  SW_ADDR  = 9'h140
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        mem_ready,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata,
    input  logic [9:0]  sw,
    output logic [7:0]  led,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR       = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] WAIT_LAST = 2'(RAM_WAIT);

    state_t      state;
    logic [7:0]  addr_q;
    logic [15:0] wdata_q;
    logic [1:0]  wait_cnt;
    logic [9:0]  sw_meta;
    logic [9:0]  sw_sync;

    logic is_ram;
    logic is_led;
    logic is_sw;

    // Decode the live address; it is only consulted in IDLE, the same edge it is captured
    assign is_ram = ~mem_addr[8];
    assign is_led = (mem_addr == LED_ADDR);
    assign is_sw  = (mem_addr == SW_ADDR);

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = (state == WR);
    assign mem_ready = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wait_cnt  <= '0;
            read_data <= '0;
            led       <= '0;
            err       <= 1'b0;
            sw_meta   <= '0;
            sw_sync   <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            case (state)
                IDLE: begin
                    if (mem_cmd != CMD_NONE) begin
                        addr_q  <= mem_addr[7:0];
                        wdata_q <= write_data;
                        state   <= DONE;
                        // IO and illegal accesses finish in one cycle; only RAM takes the long path
                        case (mem_cmd)
                            CMD_READ: begin
                                if (is_ram) begin
                                    state <= RD_ISSUE;
                                end else if (is_sw) begin
                                    read_data <= {6'b0, sw_sync};
                                end else begin
                                    err       <= 1'b1;
                                    read_data <= '0;
                                end
                            end
                            CMD_WRITE: begin
                                if (is_ram) begin
                                    state <= WR;
                                end else if (is_led) begin
                                    led <= write_data[7:0];
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                RD_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        read_data <= ram_rdata;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                WR:      state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: two instances (RAM_WAIT=0 and RAM_WAIT=2) with RAM models.
module tb_mem_bus_ctrl;

    typedef struct {
        string       name;
        int          exp_cyc;
        bit          chk_rd;
        logic [15:0] rd;
        logic        err;
        logic [7:0]  led;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] write_data;
    logic [9:0]  sw;

    logic [1:0]  cmd0, cmd2;
    logic [8:0]  addr0, addr2;
    logic [15:0] read_data0, read_data2;
    logic        mem_ready0, mem_ready2;
    logic [7:0]  ram_addr0, ram_addr2;
    logic [15:0] ram_wdata0, ram_wdata2;
    logic        ram_we0, ram_we2;
    logic [15:0] ram_rdata0, ram_rdata2;
    logic [7:0]  led0, led2;
    logic        err0, err2;

    logic [15:0] ram0 [256];
    logic [15:0] ram2 [256];

    exp_t q0[$];
    exp_t q2[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   we_cnt0 = 0;
    int   we_cyc0 = -1;

    mem_bus_ctrl #(.RAM_WAIT(0)) dut0 (
        .clk(clk), .reset(reset), .mem_cmd(cmd0), .mem_addr(addr0),
        .write_data(write_data), .read_data(read_data0), .mem_ready(mem_ready0),
        .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_we(ram_we0),
        .ram_rdata(ram_rdata0), .sw(sw), .led(led0), .err(err0)
    );

    mem_bus_ctrl #(.RAM_WAIT(2)) dut2 (
        .clk(clk), .reset(reset), .mem_cmd(cmd2), .mem_addr(addr2),
        .write_data(write_data), .read_data(read_data2), .mem_ready(mem_ready2),
        .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_we(ram_we2),
        .ram_rdata(ram_rdata2), .sw(sw), .led(led2), .err(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous RAMs with one-cycle read latency
    always @(posedge clk) begin
        if (ram_we0) ram0[ram_addr0] <= ram_wdata0;
        ram_rdata0 <= ram0[ram_addr0];
        if (ram_we2) ram2[ram_addr2] <= ram_wdata2;
        ram_rdata2 <= ram2[ram_addr2];
    end

    always @(negedge clk) begin
        if (ram_we0) begin
            we_cnt0++;
            we_cyc0 = cyc;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic monitorPop(input int unit, input logic [15:0] rd, input logic er, input logic [7:0] ld);
        exp_t e;
        if ((unit == 0 && q0.size() == 0) || (unit == 2 && q2.size() == 0)) begin
            checkOutput($sformatf("dut%0d unexpected mem_ready", unit), 32'd1, 32'd0);
        end else begin
            e = (unit == 0) ? q0.pop_front() : q2.pop_front();
            checkOutput({e.name, " ready cycle"}, cyc, e.exp_cyc);
            if (e.chk_rd) checkOutput({e.name, " read_data"}, {16'b0, rd}, {16'b0, e.rd});
            checkOutput({e.name, " err"}, {31'b0, er}, {31'b0, e.err});
            checkOutput({e.name, " led"}, {24'b0, ld}, {24'b0, e.led});
        end
    endtask

    always @(negedge clk) begin
        if (mem_ready0) monitorPop(0, read_data0, err0, led0);
        if (mem_ready2) monitorPop(2, read_data2, err2, led2);
    end

    function automatic exp_t mkExp(input string name, input int exp_cyc, input bit chk_rd,
                                   input logic [15:0] rd, input logic er, input logic [7:0] ld);
        exp_t e;
        e.name = name; e.exp_cyc = exp_cyc; e.chk_rd = chk_rd;
        e.rd = rd; e.err = er; e.led = ld;
        return e;
    endfunction

    task automatic waitDone(input int unit);
        for (int k = 0; k < 40; k++) begin
            if ((unit == 0 && q0.size() == 0) || (unit == 2 && q2.size() == 0)) break;
            @(negedge clk);
        end
        if ((unit == 0 && q0.size() != 0) || (unit == 2 && q2.size() != 0)) begin
            miscompares++;
            vectors++;
            $display("[TB] FAIL dut%0d timeout waiting for mem_ready: got none, expected pulse", unit);
            if (unit == 0) q0.delete(); else q2.delete();
        end
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT in IDLE; cycle 0 is the current cycle
    task automatic applyStimulus(input int unit, input logic [1:0] cmd, input logic [8:0] addr,
                                 input logic [15:0] wdata, input int lat, input logic [15:0] rd,
                                 input logic er, input logic [7:0] ld, input string name);
        exp_t e;
        e = mkExp(name, cyc + lat, 1'b1, rd, er, ld);
        write_data = wdata;
        if (unit == 0) begin
            q0.push_back(e);
            cmd0 = cmd; addr0 = addr;
        end else begin
            q2.push_back(e);
            cmd2 = cmd; addr2 = addr;
        end
        @(negedge clk);
        cmd0 = 2'b00;
        cmd2 = 2'b00;
        write_data = 16'hDEAD;
        waitDone(unit);
    endtask

    initial begin
        int n;
        int we_before;
        int rd_wait_cycles;

        reset = 1'b0;
        cmd0 = 2'b00; cmd2 = 2'b00;
        addr0 = '0; addr2 = '0;
        write_data = '0;
        sw = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset read_data", {16'b0, read_data0}, 32'h0);
        checkOutput("reset led", {24'b0, led0}, 32'h0);
        checkOutput("reset err", {31'b0, err0}, 32'h0);
        checkOutput("reset mem_ready", {31'b0, mem_ready0}, 32'h0);
        checkOutput("reset ram_we", {31'b0, ram_we0}, 32'h0);
        checkOutput("reset ram_addr", {24'b0, ram_addr0}, 32'h0);

        // First command is driven in the same cycle reset releases
        reset = 1'b1;
        n = cyc;
        we_before = we_cnt0;
        applyStimulus(0, 2'b10, 9'h005, 16'hBEEF, 2, 16'h0000, 1'b0, 8'h00, "ram write");
        checkOutput("ram write we pulses", we_cnt0 - we_before, 1);
        checkOutput("ram write we cycle", we_cyc0, n + 1);

        applyStimulus(0, 2'b01, 9'h005, 16'h0000, 3, 16'hBEEF, 1'b0, 8'h00, "ram read");

        applyStimulus(2, 2'b10, 9'h0FF, 16'h5A5A, 2, 16'h0000, 1'b0, 8'h00, "wait write");

        n = cyc;
        q2.push_back(mkExp("wait read", n + 5, 1'b1, 16'h5A5A, 1'b0, 8'h00));
        cmd2 = 2'b01; addr2 = 9'h0FF;
        rd_wait_cycles = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) cmd2 = 2'b00;
            checkOutput($sformatf("wait ram_addr cycle %0d", k), {24'b0, ram_addr2}, 32'hFF);
            if (dut2.state == 3'd2) rd_wait_cycles++;
        end
        checkOutput("wait rd_wait cycles", rd_wait_cycles, 3);
        waitDone(2);

        applyStimulus(0, 2'b10, 9'h100, 16'h12A5, 1, 16'hBEEF, 1'b0, 8'hA5, "led write");

        sw = 10'h3C3;
        repeat (3) @(negedge clk);
        applyStimulus(0, 2'b01, 9'h140, 16'h0000, 1, 16'h03C3, 1'b0, 8'hA5, "sw read");

        we_before = we_cnt0;
        applyStimulus(0, 2'b01, 9'h1FF, 16'h0000, 1, 16'h0000, 1'b1, 8'hA5, "unmapped read");
        checkOutput("unmapped read we pulses", we_cnt0 - we_before, 0);

        applyStimulus(0, 2'b01, 9'h005, 16'h0000, 3, 16'hBEEF, 1'b1, 8'hA5, "read after err");

        we_before = we_cnt0;
        applyStimulus(0, 2'b11, 9'h005, 16'h7777, 1, 16'hBEEF, 1'b1, 8'hA5, "cmd 11");
        checkOutput("cmd 11 we pulses", we_cnt0 - we_before, 0);

        applyStimulus(2, 2'b10, 9'h140, 16'h1111, 1, 16'h5A5A, 1'b1, 8'h00, "sw write");
        applyStimulus(2, 2'b01, 9'h100, 16'h0000, 1, 16'h0000, 1'b1, 8'h00, "led read");

        // Held command: re-accepted the cycle after DONE, second ready three cycles later
        n = cyc;
        q0.push_back(mkExp("held read 1", n + 3, 1'b1, 16'hBEEF, 1'b1, 8'hA5));
        q0.push_back(mkExp("held read 2", n + 7, 1'b1, 16'hBEEF, 1'b1, 8'hA5));
        cmd0 = 2'b01; addr0 = 9'h005;
        repeat (6) @(negedge clk);
        cmd0 = 2'b00;
        waitDone(0);

        cmd0 = 2'b01; addr0 = 9'h005;
        @(negedge clk);
        cmd0 = 2'b00;
        @(negedge clk);
        checkOutput("abort in rd_wait", {29'b0, dut0.state}, 32'd2);
        #2 reset = 1'b0;
        #1;
        checkOutput("abort state", {29'b0, dut0.state}, 32'd0);
        checkOutput("abort read_data", {16'b0, read_data0}, 32'h0);
        checkOutput("abort led", {24'b0, led0}, 32'h0);
        checkOutput("abort err", {31'b0, err0}, 32'h0);
        checkOutput("abort mem_ready", {31'b0, mem_ready0}, 32'h0);
        checkOutput("abort ram_we", {31'b0, ram_we0}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("post abort read_data", {16'b0, read_data0}, 32'h0);

        applyStimulus(0, 2'b01, 9'h005, 16'h0000, 3, 16'hBEEF, 1'b0, 8'h00, "read after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter RAM_WAIT, default 0, meaning extra RAM read wait cycles (legal range 0..3).
REQ-002 SHALL have parameter LED_ADDR, default 9'h100, meaning the LED register address (write-only).
REQ-003 SHALL have parameter SW_ADDR, default 9'h140, meaning the switch port address (read-only).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous reset, active-low.
REQ-007 mem_cmd  in  2  access command from the cpu: 00 none, 01 read, 10 write, 11 illegal.
REQ-008 mem_addr  in  9  access address from the cpu.
REQ-009 write_data  in  16  store data from the cpu datapath output.
REQ-010 read_data  out  16  registered load data returned to the cpu.
REQ-011 mem_ready  out  1  single-cycle access-complete strobe.
REQ-012 ram_addr  out  8  RAM word address.
REQ-013 ram_wdata  out  16  RAM write data.
REQ-014 ram_we  out  1  RAM write enable.
REQ-015 ram_rdata  in  16  RAM read data, synchronous with 1-cycle latency.
REQ-016 sw  in  10  asynchronous slide switches.
REQ-017 led  out  8  LED register.
REQ-018 err  out  1  sticky illegal-access flag.

Function
REQ-019 FSM states SHALL be IDLE, RD_ISSUE, RD_WAIT, WR, and DONE.
REQ-020 In IDLE with mem_cmd!=00, the block SHALL capture mem_addr and write_data into internal registers (addr_q, wdata_q) at that edge; cycle 0 is the cycle in which this occurs.
REQ-021 Decode SHALL be: addr_q[8]==0 is RAM; ==LED_ADDR is LED; ==SW_ADDR is SW; anything else is illegal.
REQ-022 A RAM read SHALL sequence IDLE->RD_ISSUE->RD_WAIT (RAM_WAIT+1 cycles, internal counter)->DONE.
REQ-023 On the edge entering DONE from RD_WAIT, read_data SHALL load ram_rdata.
REQ-024 A RAM write SHALL sequence IDLE->WR->DONE.
REQ-025 ram_we SHALL be decoded from state: 1 only in WR; ram_wdata=wdata_q.
REQ-026 ram_addr SHALL be addr_q[7:0] at all times.
REQ-027 An LED write SHALL load led<=wdata_q[7:0]... rather, led<=write_data[7:0] on the edge leaving IDLE, and the FSM SHALL go IDLE->DONE.
REQ-028 An SW read SHALL load read_data<={6'b0,sw_sync} on the edge leaving IDLE, and the FSM SHALL go IDLE->DONE.
REQ-029 sw SHALL pass through a two-flop synchronizer (sw_sync); read data SHALL always come from the second flop.
REQ-030 Illegal accesses (cmd 11, read of LED_ADDR, write of SW_ADDR, unmapped address) SHALL set err=1, load read_data<=0 on reads, and cause no RAM, LED, or read_data-on-write side effect; the FSM SHALL go IDLE->DONE.
REQ-031 A write SHALL never modify read_data; read_data SHALL hold its last value between reads.
REQ-032 mem_ready SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL always return to IDLE.
REQ-033 Latency to mem_ready: RAM read SHALL be cycle 3+RAM_WAIT; RAM write SHALL be cycle 2; LED, SW, and illegal accesses SHALL be cycle 1.
REQ-034 mem_cmd/mem_addr/write_data changes after cycle 0 SHALL be ignored until IDLE.
REQ-035 A command still asserted in IDLE after DONE SHALL start a new access (the requester drops mem_cmd on mem_ready).
REQ-036 err SHALL stay 1 until reset; it is not cleared by later legal accesses.

Reset
REQ-037 reset low SHALL immediately (asynchronously) force state=IDLE, read_data=0, led=0, err=0, addr_q=0, wdata_q=0, counter=0, and both sync flops=0.
REQ-038 Consequently, during reset ram_we=0, mem_ready=0, and ram_addr=0.
REQ-039 Reset asserted mid-access SHALL abort the access with no mem_ready, no further ram_we, and no led/read_data update.
REQ-040 The first command SHALL be accepted in the first IDLE cycle after reset deasserts.

Verification
REQ-041 Bench SHALL cover RAM write/read: RAM_WAIT=0, write 16'hBEEF to 9'h005, then read 9'h005 -> ram_we high in cycle 1 only, mem_ready in cycle 2; read mem_ready in cycle 3 with read_data=16'hBEEF.
REQ-042 Bench SHALL cover wait states: RAM_WAIT=2, read 9'h0FF -> mem_ready in cycle 5, RD_WAIT held 3 cycles, ram_addr=8'hFF throughout.
REQ-043 Bench SHALL cover IO: write 16'h12A5 to 9'h100 -> led=8'hA5 from cycle 1, mem_ready in cycle 1; sw=10'h3C3 held 3+ cycles, read 9'h140 -> read_data=16'h03C3.
REQ-044 Bench SHALL cover illegal access: read 9'h1FF -> read_data=0, err=1, mem_ready in cycle 1, no ram_we; then a legal read leaves err=1.
REQ-045 Bench SHALL cover reset mid-access: reset low while in RD_WAIT -> mem_ready never pulses, read_data=0, state IDLE, led=0 immediately.
REQ-046 Bench SHALL cover a held command: mem_cmd=01 held two extra cycles after mem_ready -> a second read starts and a second mem_ready arrives 3+RAM_WAIT cycles after re-acceptance.
